// File: rtl/controller.sv
// LC-3b multicycle control FSM: sequences fetch/decode/execute and drives every datapath select and enable.
// Latency 3 cycles (ALU/SHF/LEA/BR/JMP/JSR) or 4 cycles (loads, stores, TRAP); free-running, no backpressure.
module controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic [4:0]  StateID,
  output logic        Mux1,
  output logic [1:0]  Mux2,
  output logic [2:0]  Mux3,
  output logic [1:0]  Mux4,
  output logic [1:0]  Mux5,
  output logic [1:0]  Mux6,
  output logic [1:0]  Mux7,
  output logic        Mux11,
  output logic        Mux12,
  output logic        wrf,
  output logic        wpc,
  output logic        wir,
  output logic        lccr,
  output logic [1:0]  aluop,
  output logic [1:0]  alushop,
  output logic        wmem
);

  localparam logic [4:0] S_FETCH  = 5'd0;
  localparam logic [4:0] S_DECODE = 5'd1;
  localparam logic [4:0] S_ALU    = 5'd2;
  localparam logic [4:0] S_SHF    = 5'd3;
  localparam logic [4:0] S_LEA    = 5'd4;
  localparam logic [4:0] S_BR     = 5'd5;
  localparam logic [4:0] S_JMP    = 5'd6;
  localparam logic [4:0] S_JSR    = 5'd7;
  localparam logic [4:0] S_LDWA   = 5'd8;
  localparam logic [4:0] S_LDWM   = 5'd9;
  localparam logic [4:0] S_LDBA   = 5'd10;
  localparam logic [4:0] S_LDBM   = 5'd11;
  localparam logic [4:0] S_STWA   = 5'd12;
  localparam logic [4:0] S_STWM   = 5'd13;
  localparam logic [4:0] S_STBA   = 5'd14;
  localparam logic [4:0] S_STBM   = 5'd15;
  localparam logic [4:0] S_TRAP   = 5'd16;
  localparam logic [4:0] S_TRAPV  = 5'd17;

  logic [4:0] state, state_nxt;
  logic       wrf_i, wpc_i, wir_i, lccr_i, wmem_i;
  logic       br_taken;
  logic       unused_ir;

  // Register fields consumed directly by the datapath, not by control.
  assign unused_ir = ^{IR[8:6], IR[3:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          4'b0001, 4'b0101, 4'b1001: state_nxt = S_ALU;
          4'b1101: state_nxt = S_SHF;
          4'b1110: state_nxt = S_LEA;
          4'b0000: state_nxt = S_BR;
          4'b1100: state_nxt = S_JMP;
          4'b0100: state_nxt = S_JSR;
          4'b0110: state_nxt = S_LDWA;
          4'b0010: state_nxt = S_LDBA;
          4'b0111: state_nxt = S_STWA;
          4'b0011: state_nxt = S_STBA;
          4'b1111: state_nxt = S_TRAP;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_LDWA:  state_nxt = S_LDWM;
      S_LDBA:  state_nxt = S_LDBM;
      S_STWA:  state_nxt = S_STWM;
      S_STBA:  state_nxt = S_STBM;
      S_TRAP:  state_nxt = S_TRAPV;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign br_taken = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);

  always_comb begin
    Mux1    = 1'b0;
    Mux2    = 2'd0;
    Mux3    = 3'd0;
    Mux4    = 2'd0;
    Mux5    = 2'd0;
    Mux6    = 2'd0;
    Mux7    = 2'd0;
    Mux11   = 1'b0;
    Mux12   = 1'b0;
    wrf_i   = 1'b0;
    wpc_i   = 1'b0;
    wir_i   = 1'b0;
    lccr_i  = 1'b0;
    aluop   = 2'b00;
    alushop = 2'b00;
    wmem_i  = 1'b0;
    case (state)
      S_FETCH: begin
        wir_i = 1'b1;
        Mux4  = 2'd1;
        Mux3  = 3'd6;
        wpc_i = 1'b1;
      end
      S_ALU: begin
        Mux3   = IR[5] ? 3'd1 : 3'd0;
        aluop  = (IR[15:12] == 4'b0101) ? 2'b01 :
                 (IR[15:12] == 4'b1001) ? 2'b10 : 2'b00;
        wrf_i  = 1'b1;
        lccr_i = 1'b1;
      end
      S_SHF: begin
        Mux11   = 1'b1;
        alushop = IR[5:4];
        wrf_i   = 1'b1;
        lccr_i  = 1'b1;
      end
      S_LEA: begin
        Mux4  = 2'd1;
        Mux3  = 3'd4;
        wrf_i = 1'b1;
      end
      S_BR: begin
        Mux4  = 2'd1;
        Mux3  = 3'd4;
        wpc_i = br_taken;
      end
      S_JMP: begin
        Mux6  = 2'd1;
        wpc_i = 1'b1;
      end
      S_JSR: begin
        // BaseR is read in this same cycle, so JSRR R7 sees the old R7.
        Mux2  = 2'd3;
        Mux5  = 2'd1;
        wrf_i = 1'b1;
        wpc_i = 1'b1;
        if (IR[11]) begin
          Mux4 = 2'd1;
          Mux3 = 3'd5;
        end else begin
          Mux6 = 2'd1;
        end
      end
      S_LDWA, S_STWA: Mux3 = 3'd3;
      S_LDBA, S_STBA: Mux3 = 3'd2;
      S_LDWM: begin
        Mux1   = 1'b1;
        Mux2   = 2'd1;
        wrf_i  = 1'b1;
        lccr_i = 1'b1;
      end
      S_LDBM: begin
        Mux1   = 1'b1;
        Mux2   = 2'd2;
        wrf_i  = 1'b1;
        lccr_i = 1'b1;
      end
      S_STWM: begin
        Mux1   = 1'b1;
        Mux7   = 2'd1;
        wmem_i = 1'b1;
      end
      S_STBM: begin
        Mux1   = 1'b1;
        Mux7   = 2'd1;
        Mux12  = 1'b1;
        wmem_i = 1'b1;
      end
      S_TRAP: begin
        Mux2  = 2'd3;
        Mux5  = 2'd1;
        wrf_i = 1'b1;
        Mux4  = 2'd2;
        Mux3  = 3'd7;
      end
      S_TRAPV: begin
        Mux1  = 1'b1;
        Mux6  = 2'd2;
        wpc_i = 1'b1;
      end
      default: ;
    endcase
  end

  assign StateID = state;
  assign wrf     = wrf_i  & ~rst;
  assign wpc     = wpc_i  & ~rst;
  assign wir     = wir_i  & ~rst;
  assign lccr    = lccr_i & ~rst;
  assign wmem    = wmem_i & ~rst;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: per-instruction reference sequence of states and control words.
module tb_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic        N, Z, P;
  logic [4:0]  StateID;
  logic        Mux1, Mux11, Mux12;
  logic [1:0]  Mux2, Mux4, Mux5, Mux6, Mux7;
  logic [2:0]  Mux3;
  logic        wrf, wpc, wir, lccr, wmem;
  logic [1:0]  aluop, alushop;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0] sid;
    logic       m1;
    logic [1:0] m2;
    logic [2:0] m3;
    logic [1:0] m4, m5, m6, m7;
    logic       m11, m12, wrf, wpc, wir, lccr;
    logic [1:0] aluop, alushop;
    logic       wmem;
  } ctl_t;

  ctl_t exp_q[$];
  ctl_t obs;

  controller dut (
    .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P),
    .StateID(StateID), .Mux1(Mux1), .Mux2(Mux2), .Mux3(Mux3), .Mux4(Mux4),
    .Mux5(Mux5), .Mux6(Mux6), .Mux7(Mux7), .Mux11(Mux11), .Mux12(Mux12),
    .wrf(wrf), .wpc(wpc), .wir(wir), .lccr(lccr), .aluop(aluop),
    .alushop(alushop), .wmem(wmem)
  );

  always #5 clk = ~clk;

  assign obs = '{sid: StateID, m1: Mux1, m2: Mux2, m3: Mux3, m4: Mux4, m5: Mux5,
                 m6: Mux6, m7: Mux7, m11: Mux11, m12: Mux12, wrf: wrf, wpc: wpc,
                 wir: wir, lccr: lccr, aluop: aluop, alushop: alushop, wmem: wmem};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected micro-step sequence of one instruction, from its ISA meaning.
  task automatic build(input logic [15:0] ir, input logic n, input logic z, input logic p);
    ctl_t c;
    logic [3:0] op;
    op = ir[15:12];
    exp_q.delete();
    c = '0; c.wir = 1; c.m4 = 1; c.m3 = 6; c.wpc = 1;          // fetch, PC+2
    exp_q.push_back(c);
    c = '0; c.sid = 1;
    exp_q.push_back(c);
    c = '0;
    if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
      c.sid = 2; c.m3 = ir[5] ? 3'd1 : 3'd0;
      c.aluop = (op == 4'h1) ? 2'b00 : (op == 4'h5) ? 2'b01 : 2'b10;
      c.wrf = 1; c.lccr = 1;
      exp_q.push_back(c);
    end else if (op == 4'hD) begin
      c.sid = 3; c.m11 = 1; c.alushop = ir[5:4]; c.wrf = 1; c.lccr = 1;
      exp_q.push_back(c);
    end else if (op == 4'hE) begin
      c.sid = 4; c.m4 = 1; c.m3 = 4; c.wrf = 1;
      exp_q.push_back(c);
    end else if (op == 4'h0) begin
      c.sid = 5; c.m4 = 1; c.m3 = 4;
      c.wpc = (ir[11] && n) || (ir[10] && z) || (ir[9] && p);
      exp_q.push_back(c);
    end else if (op == 4'hC) begin
      c.sid = 6; c.m6 = 1; c.wpc = 1;
      exp_q.push_back(c);
    end else if (op == 4'h4) begin
      c.sid = 7; c.m2 = 3; c.m5 = 1; c.wrf = 1; c.wpc = 1;
      if (ir[11]) begin c.m4 = 1; c.m3 = 5; end
      else c.m6 = 1;
      exp_q.push_back(c);
    end else if (op == 4'h6 || op == 4'h2 || op == 4'h7 || op == 4'h3) begin
      // address cycle then memory cycle; word ops use off6<<1
      c.sid = (op == 4'h6) ? 8 : (op == 4'h2) ? 10 : (op == 4'h7) ? 12 : 14;
      c.m3 = (op == 4'h6 || op == 4'h7) ? 3'd3 : 3'd2;
      exp_q.push_back(c);
      c = '0; c.sid = exp_q[2].sid + 1; c.m1 = 1;
      if (op == 4'h6 || op == 4'h2) begin
        c.m2 = (op == 4'h6) ? 2'd1 : 2'd2; c.wrf = 1; c.lccr = 1;
      end else begin
        c.m7 = 1; c.m12 = (op == 4'h3); c.wmem = 1;
      end
      exp_q.push_back(c);
    end else if (op == 4'hF) begin
      c.sid = 16; c.m2 = 3; c.m5 = 1; c.wrf = 1; c.m4 = 2; c.m3 = 7;
      exp_q.push_back(c);
      c = '0; c.sid = 17; c.m1 = 1; c.m6 = 2; c.wpc = 1;
      exp_q.push_back(c);
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic n, input logic z, input logic p);
    ctl_t e;
    IR = ir; N = n; Z = z; P = p;
    build(ir, n, z, p);
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      @(negedge clk);
      check($sformatf("sid %h s%0d", ir, k), {27'd0, StateID}, {27'd0, e.sid});
      check($sformatf("ctl %h s%0d", ir, k), {2'b0, obs}, {2'b0, e});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] dir_ir [10];
    logic [2:0]  dir_nzp[10];
    dir_ir = '{16'h6000, 16'hC000, 16'h0400, 16'h0400, 16'h1021,
               16'h9000, 16'hF025, 16'h8000, 16'h4800, 16'h41C0};
    dir_nzp = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b000,
                3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    rst = 1'b1; IR = 16'h0; N = 0; Z = 0; P = 0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_sid", {27'd0, StateID}, 32'd0);
      check("rst_we", {27'd0, wrf, wpc, wir, lccr, wmem}, 32'd0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++)
      run_instr(dir_ir[i], dir_nzp[i][2], dir_nzp[i][1], dir_nzp[i][0]);
    for (int i = 0; i < 300; i++)
      run_instr(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    check("end_sid", {27'd0, StateID}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
